// File: rtl/stream_mux_pkg.sv
// Shared helpers for the stream_mux slice: index-width calculation used by
// the mux top and its round-robin arbiter.
package stream_mux_pkg;

  localparam int unsigned MAX_CHANNELS = 64;

  // Index width for n channels, never less than one bit.
  function automatic int unsigned clog2_min1(input int unsigned n);
    int unsigned w;
    w = 1;
    while ((32'd1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/stream_mux_rr.sv
// Combinational round-robin search: the first set req bit starting at ptr,
// wrapping past CHANNELS-1 back to 0.
module rr_arbiter
  import stream_mux_pkg::*;
#(
  parameter  int unsigned CHANNELS = 16,
  localparam int unsigned SEL_W    = clog2_min1(CHANNELS)
) (
  input  logic [CHANNELS-1:0] req,
  input  logic [SEL_W-1:0]    ptr,
  output logic                hit,
  output logic [SEL_W-1:0]    idx
);

  always_comb begin
    int unsigned c;
    c   = '0;
    hit = 1'b0;
    idx = '0;
    for (int unsigned k = 0; k < CHANNELS; k++) begin
      c = 32'(ptr) + k;
      if (c >= CHANNELS) c = c - CHANNELS;
      if (!hit && req[c[SEL_W-1:0]]) begin
        hit = 1'b1;
        idx = c[SEL_W-1:0];
      end
    end
  end

endmodule

// File: rtl/stream_mux.sv
// M-channel valid/ready stream mux with round-robin or forced selection and a
// single registered output stage. Optional packet lock: STREAM_MUX_PKT_LOCK_EN.
module stream_mux
  import stream_mux_pkg::*;
#(
  parameter  int unsigned N        = 8,
  parameter  int unsigned CHANNELS = 16,
  localparam int unsigned SEL_W    = clog2_min1(CHANNELS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [CHANNELS*N-1:0] in_data,
  input  logic [CHANNELS-1:0]   in_valid,
  input  logic [CHANNELS-1:0]   in_last,
  output logic [CHANNELS-1:0]   in_ready,
  input  logic                  force_en,
  input  logic [SEL_W-1:0]      force_sel,
  output logic [N-1:0]          out_data,
  output logic                  out_valid,
  output logic                  out_last,
  output logic [SEL_W-1:0]      out_chan,
  input  logic                  out_ready
);

  typedef struct packed {
    logic             hit;
    logic [SEL_W-1:0] idx;
  } grant_t;

  logic [N-1:0]        chan_data [CHANNELS];
  logic [CHANNELS-1:0] frc_req;
  grant_t              rr_g, frc_g, grant;
  logic                rr_mode, can_load, accept;

  logic [N-1:0]     out_data_q,  out_data_d;
  logic             out_valid_q, out_valid_d;
  logic             out_last_q,  out_last_d;
  logic [SEL_W-1:0] out_chan_q,  out_chan_d;
  logic [SEL_W-1:0] rr_ptr_q,    rr_ptr_d;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_slice
    assign chan_data[i] = in_data[i*N +: N];
  end

  // Forced path reuses the arbiter with a single-bit request mask.
  always_comb begin
    frc_req = '0;
    if (32'(force_sel) < CHANNELS) frc_req[force_sel] = in_valid[force_sel];
  end

  rr_arbiter #(.CHANNELS(CHANNELS)) u_rr (
    .req (in_valid),
    .ptr (rr_ptr_q),
    .hit (rr_g.hit),
    .idx (rr_g.idx)
  );

  rr_arbiter #(.CHANNELS(CHANNELS)) u_frc (
    .req (frc_req),
    .ptr ('0),
    .hit (frc_g.hit),
    .idx (frc_g.idx)
  );

`ifdef STREAM_MUX_PKT_LOCK_EN
  logic             lock_q,      lock_d;
  logic [SEL_W-1:0] lock_chan_q, lock_chan_d;

  always_comb begin
    grant = rr_g;
    if (lock_q) begin
      grant.hit = in_valid[lock_chan_q];
      grant.idx = lock_chan_q;
    end else if (force_en) begin
      grant = frc_g;
    end
  end

  assign rr_mode = lock_q | !force_en;

  always_comb begin
    lock_d      = lock_q;
    lock_chan_d = lock_chan_q;
    if (accept) begin
      lock_d      = !in_last[grant.idx];
      lock_chan_d = grant.idx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_q      <= 1'b0;
      lock_chan_q <= '0;
    end else begin
      lock_q      <= lock_d;
      lock_chan_q <= lock_chan_d;
    end
  end
`else
  assign grant   = force_en ? frc_g : rr_g;
  assign rr_mode = !force_en;
`endif

  // Ready is suppressed while reset is held so no producer sees a handshake.
  always_comb begin
    can_load = !out_valid_q || out_ready;
    accept   = rst_n && can_load && grant.hit;
    in_ready = accept ? (CHANNELS'(1) << grant.idx) : '0;
  end

  always_comb begin
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_chan_d  = out_chan_q;
    rr_ptr_d    = rr_ptr_q;
    if (accept) begin
      out_data_d  = chan_data[grant.idx];
      out_last_d  = in_last[grant.idx];
      out_chan_d  = grant.idx;
      out_valid_d = 1'b1;
      if (rr_mode) rr_ptr_d = (32'(grant.idx) == CHANNELS - 1) ? '0 : grant.idx + 1'b1;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_chan_q  <= '0;
      rr_ptr_q    <= '0;
    end else begin
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_chan_q  <= out_chan_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign out_chan  = out_chan_q;

endmodule
